// File: rtl/data_unpacker_pkg.sv
// Shared firmware codes, state encoding and width helpers for the data unpacker.
package data_unpacker_pkg;

  localparam logic [7:0] FW_N = 8'd0;
  localparam logic [7:0] FW_M = 8'd1;
  localparam logic [7:0] FW_1 = 8'd2;

  typedef enum logic {IDLE, DRAIN} state_e;

  // Width of a lane-count field able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int chain_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_unpacker_lane_group_select.sv
// Combinational extraction of up to grp_i lanes starting at off_i, packed down to lane 0 with zero fill.
module lane_group_select
  import data_unpacker_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] src_i,
  input  logic [cnt_w(N)-1:0]          off_i,
  input  logic [cnt_w(N)-1:0]          grp_i,
  output logic [N-1:0][DATA_WIDTH-1:0] lanes_o,
  output logic [cnt_w(N)-1:0]          cnt_o
);

  localparam int CW = cnt_w(N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] rem;

  always_comb begin
    rem     = CW'(N) - off_i;
    cnt_o   = (grp_i < rem) ? grp_i : rem;
    lanes_o = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(cnt_o)) begin
        lanes_o[k] = src_i[IW'(int'(off_i) + k)];
      end
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Unpacks N-lane trace vectors into groups of N, M or 1 lanes per chain firmware byte.
// Optional DATA_UNPACKER_STATS_EN adds accepted/emitted/dropped counters.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int N                  = 8,
  parameter int M                  = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tracing,
  input  logic [7:0]                      configId,
  input  logic [7:0]                      configData,
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic [chain_w(MAX_CHAINS)-1:0]  chainId_in,
  input  logic [cnt_w(N)-1:0]             count_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]    vector_in,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic [N-1:0][DATA_WIDTH-1:0]    vector_out,
  output logic [cnt_w(N)-1:0]             count_out,
  output logic [chain_w(MAX_CHAINS)-1:0]  chainId_out
`ifdef DATA_UNPACKER_STATS_EN
  ,
  output logic [31:0]                     vectors_in_cnt,
  output logic [31:0]                     groups_out_cnt,
  output logic [31:0]                     dropped_cnt
`endif
);

  localparam int CW  = cnt_w(N);
  localparam int CHW = chain_w(MAX_CHAINS);

  function automatic logic [CW-1:0] grp_of(input logic [7:0] code);
    case (code)
      FW_N:    return CW'(N);
      FW_M:    return CW'(M);
      FW_1:    return CW'(1);
      default: return '0;
    endcase
  endfunction

  state_e                         state_q, state_d;
  logic [MAX_CHAINS-1:0][7:0]     fw_q, fw_d;
  logic [7:0]                     bc_q, bc_d;
  logic [N-1:0][DATA_WIDTH-1:0]   buf_q, buf_d;
  logic [CW-1:0]                  rd_q, rd_d;
  logic [CW-1:0]                  grp_q, grp_d;
  logic [CHW-1:0]                 chain_q, chain_d;
  logic                           vld_q, vld_d;
  logic [N-1:0][DATA_WIDTH-1:0]   vout_q, vout_d;
  logic [CW-1:0]                  cout_q, cout_d;

  logic                           hs, last, accept, drop;
  logic [CW-1:0]                  rd_next, cnt_clamp, g_new;
  logic [7:0]                     fw_sel;
  logic [N-1:0][DATA_WIDTH-1:0]   sel_src, sel_lanes;
  logic [CW-1:0]                  sel_off, sel_grp, sel_cnt;

  always_comb begin
    hs        = vld_q & ready_in;
    rd_next   = rd_q + cout_q;
    last      = (rd_next == CW'(N));
    // Free the buffer during the final handshake so the next vector lands without a bubble.
    ready_out = (state_q == IDLE) | ((state_q == DRAIN) & hs & last);
    accept    = valid_in & ready_out;

    fw_sel = 8'hFF;
    for (int c = 0; c < MAX_CHAINS; c++) begin
      if (int'(chainId_in) == c) fw_sel = fw_q[c];
    end
    g_new     = grp_of(fw_sel);
    cnt_clamp = (count_in > CW'(N)) ? CW'(N) : count_in;
    drop      = (g_new == '0) | (count_in == '0);

    sel_src = accept ? vector_in : buf_q;
    sel_off = accept ? (CW'(N) - cnt_clamp) : rd_next;
    sel_grp = accept ? g_new : grp_q;
  end

  lane_group_select #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sel (
    .src_i   (sel_src),
    .off_i   (sel_off),
    .grp_i   (sel_grp),
    .lanes_o (sel_lanes),
    .cnt_o   (sel_cnt)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    rd_d    = rd_q;
    grp_d   = grp_q;
    chain_d = chain_q;
    vld_d   = vld_q;
    vout_d  = vout_q;
    cout_d  = cout_q;
    if (accept) begin
      if (drop) begin
        state_d = IDLE;
        vld_d   = 1'b0;
        vout_d  = '0;
        cout_d  = '0;
      end else begin
        state_d = DRAIN;
        buf_d   = vector_in;
        grp_d   = g_new;
        chain_d = chainId_in;
        rd_d    = sel_off;
        vld_d   = 1'b1;
        vout_d  = sel_lanes;
        cout_d  = sel_cnt;
      end
    end else if (hs) begin
      if (last) begin
        state_d = IDLE;
        vld_d   = 1'b0;
        vout_d  = '0;
        cout_d  = '0;
      end else begin
        rd_d   = rd_next;
        vout_d = sel_lanes;
        cout_d = sel_cnt;
      end
    end
  end

  // Firmware bytes stream in one per cycle while this block is addressed.
  always_comb begin
    fw_d = fw_q;
    bc_d = bc_q;
    if (!tracing) begin
      if (configId == 8'(PERSONAL_CONFIG_ID)) begin
        if (int'(bc_q) < MAX_CHAINS) begin
          for (int c = 0; c < MAX_CHAINS; c++) begin
            if (int'(bc_q) == c) fw_d[c] = configData;
          end
          bc_d = bc_q + 8'd1;
        end
      end else begin
        bc_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    if (reset) begin
      state_q <= IDLE;
      fw_q    <= INITIAL_FIRMWARE;
      bc_q    <= '0;
      rd_q    <= '0;
      grp_q   <= '0;
      chain_q <= '0;
      vld_q   <= 1'b0;
      vout_q  <= '0;
      cout_q  <= '0;
    end else begin
      state_q <= state_d;
      fw_q    <= fw_d;
      bc_q    <= bc_d;
      rd_q    <= rd_d;
      grp_q   <= grp_d;
      chain_q <= chain_d;
      vld_q   <= vld_d;
      vout_q  <= vout_d;
      cout_q  <= cout_d;
    end
  end

  assign valid_out   = vld_q;
  assign vector_out  = vout_q;
  assign count_out   = cout_q;
  assign chainId_out = chain_q;

`ifdef DATA_UNPACKER_STATS_EN
  logic [31:0] vin_q, gout_q, drp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vin_q  <= '0;
      gout_q <= '0;
      drp_q  <= '0;
    end else begin
      if (accept)        vin_q  <= vin_q + 32'd1;
      if (hs)            gout_q <= gout_q + 32'd1;
      if (accept & drop) drp_q  <= drp_q + 32'd1;
    end
  end

  assign vectors_in_cnt = vin_q;
  assign groups_out_cnt = gout_q;
  assign dropped_cnt    = drp_q;
`endif

endmodule

// File: tb/tb_data_unpacker.sv
// Directed self-checking bench for data_unpacker (default parameters N=8, M=2).
module tb_data_unpacker;

  logic              clk = 1'b0;
  logic              reset;
  logic              tracing;
  logic [7:0]        configId;
  logic [7:0]        configData;
  logic              valid_in;
  logic              ready_out;
  logic [1:0]        chainId_in;
  logic [3:0]        count_in;
  logic [7:0][31:0]  vector_in;
  logic              valid_out;
  logic              ready_in;
  logic [7:0][31:0]  vector_out;
  logic [3:0]        count_out;
  logic [1:0]        chainId_out;
`ifdef DATA_UNPACKER_STATS_EN
  logic [31:0]       vectors_in_cnt, groups_out_cnt, dropped_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_unpacker dut (
    .clk         (clk),
    .reset       (reset),
    .tracing     (tracing),
    .configId    (configId),
    .configData  (configData),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .chainId_in  (chainId_in),
    .count_in    (count_in),
    .vector_in   (vector_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .vector_out  (vector_out),
    .count_out   (count_out),
    .chainId_out (chainId_out)
`ifdef DATA_UNPACKER_STATS_EN
    ,
    .vectors_in_cnt (vectors_in_cnt),
    .groups_out_cnt (groups_out_cnt),
    .dropped_cnt    (dropped_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][31:0] mkvec(input int lane0, input int cnt, input int v0);
    logic [7:0][31:0] v;
    v = '0;
    for (int i = 0; i < cnt; i++) v[lane0 + i] = 32'(v0 + i);
    return v;
  endfunction

  task automatic chk_grp(input string tag, input int cnt, input int v0, input int chain);
    chk({tag, "_vld"},   256'(valid_out),   256'(1));
    chk({tag, "_cnt"},   256'(count_out),   256'(cnt));
    chk({tag, "_vec"},   256'(vector_out),  256'(mkvec(0, cnt, v0)));
    chk({tag, "_chain"}, 256'(chainId_out), 256'(chain));
  endtask

  task automatic offer(input int chain, input int cnt, input logic [7:0][31:0] v);
    valid_in   = 1'b1;
    chainId_in = 2'(chain);
    count_in   = 4'(cnt);
    vector_in  = v;
  endtask

  task automatic load_fw(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    tracing  = 1'b0;
    configId = 8'd1;
    tick();
    configId = 8'd0;
    configData = b0; tick();
    configData = b1; tick();
    configData = b2; tick();
    configData = b3; tick();
    tracing  = 1'b1;
    configId = 8'd1;
  endtask

  initial begin
    reset = 1'b1; tracing = 1'b1; configId = 8'd1; configData = 8'd0;
    valid_in = 1'b0; chainId_in = '0; count_in = '0; vector_in = '0; ready_in = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_vld",   256'(valid_out),   256'(0));
    chk("rst_vec",   256'(vector_out),  256'(0));
    chk("rst_cnt",   256'(count_out),   256'(0));
    chk("rst_chain", 256'(chainId_out), 256'(0));
    chk("rst_rdy",   256'(ready_out),   256'(1));

    // Full-width group, firmware 0 everywhere after reset.
    offer(0, 8, mkvec(0, 8, 1));
    tick();
    valid_in = 1'b0;
    chk_grp("fwN", 8, 1, 0);
    tick();
    chk("fwN_done", 256'(valid_out), 256'(0));

    load_fw(8'd2, 8'd1, 8'd0, 8'd7);

    // Chain1 in M mode, then back-to-back vector on chain2 during the last group.
    offer(1, 8, mkvec(0, 8, 1));
    tick();
    valid_in = 1'b0;
    chk_grp("m_g0", 2, 1, 1);
    chk("m_g0_rdy", 256'(ready_out), 256'(0));
    tick(); chk_grp("m_g1", 2, 3, 1);
    tick(); chk_grp("m_g2", 2, 5, 1);
    tick(); chk_grp("m_g3", 2, 7, 1);
    offer(2, 8, mkvec(0, 8, 11));
    #1;
    chk("b2b_rdy", 256'(ready_out), 256'(1));
    tick();
    valid_in = 1'b0;
    chk_grp("b2b", 8, 11, 2);
    tick();
    chk("b2b_done", 256'(valid_out), 256'(0));

    // Single-lane groups from a 3-element vector on chain0.
    offer(0, 3, mkvec(5, 3, 6));
    tick();
    chk_grp("s_g0", 1, 6, 0);
    chk("s_g0_rdy", 256'(ready_out), 256'(0));
    tick();
    chk_grp("s_g1", 1, 7, 0);
    chk("s_g1_rdy", 256'(ready_out), 256'(0));
    tick();
    chk_grp("s_g2", 1, 8, 0);
    chk("s_g2_rdy", 256'(ready_out), 256'(1));
    valid_in = 1'b0;
    tick();
    chk("s_done", 256'(valid_out), 256'(0));

    // Partial final group in M mode.
    offer(1, 3, mkvec(5, 3, 6));
    tick();
    valid_in = 1'b0;
    chk_grp("p_g0", 2, 6, 1);
    tick();
    chk_grp("p_g1", 1, 8, 1);
    tick();
    chk("p_done", 256'(valid_out), 256'(0));

    // Backpressure mid-drain, then reset mid-drain.
    offer(1, 8, mkvec(0, 8, 21));
    tick();
    valid_in = 1'b0;
    chk_grp("bp_g0", 2, 21, 1);
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_grp("bp_hold", 2, 21, 1);
    end
    ready_in = 1'b1;
    tick();
    chk_grp("bp_g1", 2, 23, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_vld", 256'(valid_out), 256'(0));
    chk("mrst_rdy", 256'(ready_out), 256'(1));
    offer(1, 8, mkvec(0, 8, 31));
    tick();
    valid_in = 1'b0;
    chk_grp("fw_restored", 8, 31, 1);
    tick();
    chk("fwr_done", 256'(valid_out), 256'(0));

    // Drop: chain3 firmware code 7, and count_in==0 on a valid chain.
    load_fw(8'd2, 8'd1, 8'd0, 8'd7);
    offer(3, 8, mkvec(0, 8, 41));
    #1;
    chk("drop_rdy", 256'(ready_out), 256'(1));
    tick();
    valid_in = 1'b0;
    chk("drop_vld", 256'(valid_out), 256'(0));
    chk("drop_rdy2", 256'(ready_out), 256'(1));
    offer(2, 0, mkvec(0, 8, 51));
    tick();
    valid_in = 1'b0;
    chk("cnt0_vld", 256'(valid_out), 256'(0));
    tick();
    chk("cnt0_vld2", 256'(valid_out), 256'(0));
`ifdef DATA_UNPACKER_STATS_EN
    chk("st_drop", 256'(dropped_cnt),    256'(2));
    chk("st_vin",  256'(vectors_in_cnt), 256'(3));
    chk("st_gout", 256'(groups_out_cnt), 256'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
